// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: one fully connected MLP layer on a single shared MAC.
// Computes R neuron outputs, each a C-term signed-magnitude dot product.
// Results are streamed out over a valid/ready handshake.
// Build option: define MLP_RELU_EN to clamp negative results to zero.
// Word format: `N-bit signed-magnitude with `Q fraction bits.
// Both values normally come from config.svh; the defaults below apply when it is absent.
`ifndef N
`define N 32
`endif
`ifndef Q
`define Q 17
`endif

module mlp_layer_sequencer #(
  parameter  int R  = 6,
  parameter  int C  = 6,
  localparam int RW = $clog2(R),
  localparam int CW = $clog2(C)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_we,
  input  logic [CW-1:0] x_idx,
  input  logic [`N-1:0] x_data,
  input  logic          w_we,
  input  logic [RW-1:0] w_row,
  input  logic [CW-1:0] w_col,
  input  logic [`N-1:0] w_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [RW-1:0] y_idx,
  output logic [`N-1:0] y_data,
  output logic          ovf
);

  localparam int NW = `N;
  localparam int QW = `Q;
  localparam int AW = NW + CW + 1;   // accumulator cannot wrap over C terms
  localparam int PW = 2 * NW - 2;    // full magnitude product width
  localparam logic [NW-2:0] MAG_MAX = '1;
  localparam logic [CW-1:0] C_LAST  = CW'(C - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(R - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

  state_t               state;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic signed [AW-1:0] acc;

  logic [NW-1:0] x_mem [C];
  logic [NW-1:0] w_mem [R][C];

  logic [NW-1:0]        op_a, op_b;
  logic [PW-1:0]        full_mag, shifted_mag;
  logic [NW-2:0]        prod_mag;
  logic                 prod_sat, prod_neg;
  logic signed [AW-1:0] prod_val, acc_sum;

  logic [AW-1:0]        sum_mag;
  logic                 sum_neg, res_sat;
  logic [NW-1:0]        res_word;

  // Operand storage: cleared on reset, writable only while idle, out-of-range indices dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C; i++) x_mem[i] <= '0;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) w_mem[i][j] <= '0;
    end else if (!busy) begin
      if (x_we && x_idx <= C_LAST) x_mem[x_idx] <= x_data;
      if (w_we && w_row <= R_LAST && w_col <= C_LAST) w_mem[w_row][w_col] <= w_data;
    end
  end

  // Signed-magnitude product of the current term, saturated, then widened to two's complement.
  always_comb begin
    op_a        = x_mem[col];
    op_b        = w_mem[row][col];
    full_mag    = PW'(op_a[NW-2:0]) * PW'(op_b[NW-2:0]);
    shifted_mag = full_mag >> QW;
    prod_sat    = shifted_mag > PW'(MAG_MAX);
    prod_mag    = prod_sat ? MAG_MAX : shifted_mag[NW-2:0];
    // a zero magnitude is always treated as +0
    prod_neg    = (op_a[NW-1] ^ op_b[NW-1]) && (prod_mag != '0);
    prod_val    = {{(CW + 2){1'b0}}, prod_mag};
    if (prod_neg) prod_val = -prod_val;
    acc_sum     = acc + prod_val;
  end

  // Convert the final sum (including the last term) back to saturated signed-magnitude.
  always_comb begin
    sum_neg  = acc_sum[AW-1];
    sum_mag  = sum_neg ? -acc_sum : acc_sum;
    res_sat  = sum_mag > AW'(MAG_MAX);
    res_word = {sum_neg, res_sat ? MAG_MAX : sum_mag[NW-2:0]};
`ifdef MLP_RELU_EN
    if (sum_neg) begin
      res_word = '0;
      res_sat  = 1'b0;
    end
`endif
  end

  // Sequencer: one MAC term per cycle, hold each result until accepted, pulse done at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_valid <= 1'b0;
      y_idx   <= '0;
      y_data  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_MAC;
            busy  <= 1'b1;
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            ovf   <= 1'b0;
          end
        end
        S_MAC: begin
          if (prod_sat) ovf <= 1'b1;
          if (col == C_LAST) begin
            y_data  <= res_word;
            y_idx   <= row;
            y_valid <= 1'b1;
            state   <= S_EMIT;
            if (res_sat) ovf <= 1'b1;
          end else begin
            acc <= acc_sum;
            col <= col + 1'b1;
          end
        end
        S_EMIT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (row == R_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              row   <= row + 1'b1;
              col   <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
